lsu_reorder_queue: RTL and testbench
====================================

// Module: lsu_reorder_queue
// PURPOSE
//  In-order load/store request queue between the core LSU port and l1_data_cache (upstream of L1D).
//  Accepts core requests, assigns each one a tag, and issues them to L1D in program order.
//  L1D may complete requests out of order through its MSHRs; responses are matched by tag.
//  Responses return to the core strictly in program order.
// PARAMETERS
//  DEPTH      4   entries; power of 2, >=2; tag = entry index zero-extended
//  TAG_BITS   10  width of L1D tag field; must be >= $clog2(DEPTH)
//  ADDR_BITS  64  request address width
//  DATA_BITS  64  load/store data width
// PORTS
//  clk_in                  in   1          clock, rising edge
//  rst_in                  in   1          asynchronous reset, active-high
//  core_valid_in           in   1          core request valid
//  core_ready_out          out  1          queue can accept a request
//  core_addr_in            in   ADDR_BITS  request address
//  core_value_in           in   DATA_BITS  store data
//  core_we_in              in   1          1=store, 0=load
//  l1d_valid_out           out  1          request to L1D valid (lsu_valid_in of L1D)
//  l1d_ready_in            in   1          L1D accepts request (lsu_ready_out of L1D)
//  l1d_addr_out            out  ADDR_BITS  issued address
//  l1d_value_out           out  DATA_BITS  issued store data
//  l1d_we_out              out  1          issued write enable
//  l1d_tag_out             out  TAG_BITS   issued tag
//  l1d_valid_in            in   1          L1D response valid
//  l1d_ready_out           out  1          queue accepts responses
//  l1d_value_in            in   DATA_BITS  load data (ignored for stores)
//  l1d_tag_in              in   TAG_BITS   response tag
//  l1d_write_complete_in   in   1          response is a store completion
//  resp_valid_out          out  1          in-order response to core valid
//  resp_ready_in           in   1          core accepts response
//  resp_value_out          out  DATA_BITS  load data; 0 for stores
//  resp_we_out             out  1          response belongs to a store
//  tag_err_out             out  1          sticky: response with bad tag seen
// BEHAVIOUR
//  Reset: all entries FREE; head/issue/tail ptrs=0; all outputs 0, except l1d_ready_out=1 after reset release.
//  Entry state per slot: FREE -> PEND (alloc) -> ISSUED (L1D handshake) -> DONE (response) -> FREE (retire).
//  Alloc: on core_valid_in && core_ready_out, write the tail slot, set it PEND, tail++ (wraps mod DEPTH).
//  core_ready_out = (count != DEPTH); registered only, with no path from resp_ready_in.
//  Issue: l1d_valid_out = slot[issue_ptr]==PEND; outputs come from slot registers.
//    Valid and payload stay stable until l1d_ready_in; on handshake, slot becomes ISSUED and issue_ptr++.
//  Earliest issue is the cycle after alloc.
//  Response: l1d_ready_out=1 always; l1d_valid_in with slot[tag[idx]]==ISSUED and upper tag bits 0
//    -> slot becomes DONE and stores the value (stores store 0).
//  Otherwise the response is dropped and tag_err_out is set; it clears only on reset.
//  Retire: resp_valid_out = slot[head]==DONE. On resp_ready_in, slot becomes FREE and head++.
//    Earliest resp_valid_out is the cycle after the response.
//  Simultaneous events: alloc+retire in one cycle keeps count unchanged.
//  Alloc into a slot retiring in the same cycle is impossible because ready uses the registered count.
//  Response to the head slot while resp_valid_out is low: visible next cycle.
//  Full: core_ready_out=0 until a retire. Empty: all valids 0.
//  Reset mid-operation clears all state; in-flight L1D responses that arrive after reset hit a FREE slot,
//  are dropped, and set tag_err_out.
// CONFIGURATION
//  LSU_RQ_STATS_EN defined: adds outputs stat_issued_out[31:0], stat_stall_out[31:0],
//    stat_ooo_out[31:0], all saturating and reset to 0.
//    stat_issued_out counts L1D handshakes.
//    stat_stall_out counts cycles with core_valid_in && !core_ready_out.
//    stat_ooo_out counts accepted responses whose tag != head index.
//  LSU_RQ_STATS_EN undefined: ports and logic absent; behaviour otherwise identical.
// STRUCTURE
//  Package lsu_rq_pkg: typedef enum {FREE,PEND,ISSUED,DONE} rq_state_e; typedef struct rq_entry_t
//    (addr, value, we, state); function idx_to_tag().
//  No sub-module; entry array plus three pointers and a count register in one module.
// TESTING
//  Load 0x2000, L1D ready, response tag 0, value 0x12345678
//    -> l1d_valid_out 1 cycle after accept; resp_value_out=0x12345678 1 cycle after response.
//  Loads 0x5000, 0x7004, 0x9004, 0xF004 issued as tags 0..3; responses tags 2,0,3,1
//    -> core sees responses in order 0x5000..0xF004; stat_ooo_out=3 when LSU_RQ_STATS_EN.
//  Fifth request while 4 outstanding -> core_ready_out=0; retiring the head lets it alloc next cycle into slot 0.
//  Store 0x4050 value 0xC0C0C0C0, l1d_ready_in held 0 for 5 cycles -> l1d_* stable for all 5 cycles;
//    write_complete -> resp_we_out=1, resp_value_out=0.
//  Response tag 2 while slot 2 FREE -> dropped, tag_err_out=1, queue state unchanged.
//  Assert rst_in with 3 entries ISSUED -> outputs 0 immediately; late response tag 1 -> tag_err_out=1.

Source files
------------

// File: rtl/lsu_rq_pkg.sv
// Shared types for the LSU reorder queue: per-slot state, slot record and tag helper.
package lsu_rq_pkg;

    localparam int unsigned RQ_ADDR_MAX = 64;
    localparam int unsigned RQ_DATA_MAX = 64;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        PEND   = 2'd1,
        ISSUED = 2'd2,
        DONE   = 2'd3
    } rq_state_e;

    // Slot payload is sized for the widest supported address/data; the top slices it down.
    typedef struct packed {
        logic [RQ_ADDR_MAX-1:0] addr;
        logic [RQ_DATA_MAX-1:0] value;
        logic                   we;
        rq_state_e              state;
    } rq_entry_t;

    function automatic logic [31:0] idx_to_tag(input int unsigned idx);
        return 32'(idx);
    endfunction

endpackage

// File: rtl/lsu_reorder_queue.sv
// In-order LSU request queue in front of L1D: tags requests by slot index, accepts
// out-of-order completions and retires in program order. Optional counters: LSU_RQ_STATS_EN.
module lsu_reorder_queue
    import lsu_rq_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TAG_BITS  = 10,
    parameter int unsigned ADDR_BITS = 64,
    parameter int unsigned DATA_BITS = 64
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 core_valid_in,
    output logic                 core_ready_out,
    input  logic [ADDR_BITS-1:0] core_addr_in,
    input  logic [DATA_BITS-1:0] core_value_in,
    input  logic                 core_we_in,
    output logic                 l1d_valid_out,
    input  logic                 l1d_ready_in,
    output logic [ADDR_BITS-1:0] l1d_addr_out,
    output logic [DATA_BITS-1:0] l1d_value_out,
    output logic                 l1d_we_out,
    output logic [TAG_BITS-1:0]  l1d_tag_out,
    input  logic                 l1d_valid_in,
    output logic                 l1d_ready_out,
    input  logic [DATA_BITS-1:0] l1d_value_in,
    input  logic [TAG_BITS-1:0]  l1d_tag_in,
    input  logic                 l1d_write_complete_in,
    output logic                 resp_valid_out,
    input  logic                 resp_ready_in,
    output logic [DATA_BITS-1:0] resp_value_out,
    output logic                 resp_we_out,
`ifdef LSU_RQ_STATS_EN
    output logic [31:0]          stat_issued_out,
    output logic [31:0]          stat_stall_out,
    output logic [31:0]          stat_ooo_out,
`endif
    output logic                 tag_err_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    rq_entry_t          entries_q [DEPTH];
    rq_entry_t          entries_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   issue_q, issue_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ready_q, ready_d;
    logic               tag_err_q, tag_err_d;

    logic               alloc_fire;
    logic               issue_fire;
    logic               retire_fire;
    logic [PTR_W-1:0]   rsp_idx;
    logic               rsp_upper_zero;
    logic               rsp_ok;
    logic               rsp_bad;

    assign l1d_valid_out  = entries_q[issue_q].state == PEND;
    assign l1d_addr_out   = entries_q[issue_q].addr[ADDR_BITS-1:0];
    assign l1d_value_out  = entries_q[issue_q].value[DATA_BITS-1:0];
    assign l1d_we_out     = entries_q[issue_q].we;
    assign l1d_tag_out    = TAG_BITS'(idx_to_tag(32'(issue_q)));

    assign resp_valid_out = entries_q[head_q].state == DONE;
    assign resp_value_out = entries_q[head_q].value[DATA_BITS-1:0];
    assign resp_we_out    = entries_q[head_q].we;

    // Ready is a flop so the core handshake never depends on resp_ready_in.
    assign core_ready_out = ready_q;
    assign l1d_ready_out  = ~rst_in;
    assign tag_err_out    = tag_err_q;

    assign alloc_fire     = core_valid_in & ready_q;
    assign issue_fire     = l1d_valid_out & l1d_ready_in;
    assign retire_fire    = resp_valid_out & resp_ready_in;

    assign rsp_idx        = l1d_tag_in[PTR_W-1:0];
    assign rsp_upper_zero = (l1d_tag_in >> PTR_W) == '0;
    assign rsp_ok         = l1d_valid_in & l1d_ready_out & rsp_upper_zero
                            & (entries_q[rsp_idx].state == ISSUED);
    assign rsp_bad        = l1d_valid_in & l1d_ready_out & ~rsp_ok;

    // The four events always touch distinct slots (each requires a different state),
    // so their updates never collide.
    always_comb begin
        entries_d = entries_q;
        if (issue_fire) begin
            entries_d[issue_q].state = ISSUED;
        end
        if (rsp_ok) begin
            entries_d[rsp_idx].state = DONE;
            entries_d[rsp_idx].value = (entries_q[rsp_idx].we | l1d_write_complete_in)
                                       ? '0 : RQ_DATA_MAX'(l1d_value_in);
        end
        if (retire_fire) begin
            entries_d[head_q].state = FREE;
        end
        if (alloc_fire) begin
            entries_d[tail_q].addr  = RQ_ADDR_MAX'(core_addr_in);
            entries_d[tail_q].value = RQ_DATA_MAX'(core_value_in);
            entries_d[tail_q].we    = core_we_in;
            entries_d[tail_q].state = PEND;
        end
    end

    always_comb begin
        head_d  = retire_fire ? head_q + PTR_W'(1) : head_q;
        issue_d = issue_fire  ? issue_q + PTR_W'(1) : issue_q;
        tail_d  = alloc_fire  ? tail_q + PTR_W'(1) : tail_q;
        unique case ({alloc_fire, retire_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ready_d   = count_d != CNT_W'(DEPTH);
        tag_err_d = tag_err_q | rsp_bad;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q    <= '0;
            issue_q   <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ready_q   <= 1'b0;
            tag_err_q <= 1'b0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            issue_q   <= issue_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            tag_err_q <= tag_err_d;
        end
    end

`ifdef LSU_RQ_STATS_EN
    logic [31:0] stat_issued_q, stat_stall_q, stat_ooo_q;
    logic        stall_evt, ooo_evt;

    assign stall_evt = core_valid_in & ~ready_q;
    assign ooo_evt   = rsp_ok & (rsp_idx != head_q);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
            stat_ooo_q    <= '0;
        end else begin
            if (issue_fire && stat_issued_q != '1) stat_issued_q <= stat_issued_q + 32'd1;
            if (stall_evt && stat_stall_q != '1)   stat_stall_q  <= stat_stall_q + 32'd1;
            if (ooo_evt && stat_ooo_q != '1)       stat_ooo_q    <= stat_ooo_q + 32'd1;
        end
    end

    assign stat_issued_out = stat_issued_q;
    assign stat_stall_out  = stat_stall_q;
    assign stat_ooo_out    = stat_ooo_q;
`endif

endmodule

// File: tb/tb_lsu_reorder_queue.sv
// Randomized + directed bench for lsu_reorder_queue against a program-order queue model.
module tb_lsu_reorder_queue;

    localparam int DEPTH    = 4;
    localparam int TAG_BITS = 10;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        core_valid_in;
    logic        core_ready_out;
    logic [63:0] core_addr_in;
    logic [63:0] core_value_in;
    logic        core_we_in;
    logic        l1d_valid_out;
    logic        l1d_ready_in;
    logic [63:0] l1d_addr_out;
    logic [63:0] l1d_value_out;
    logic        l1d_we_out;
    logic [TAG_BITS-1:0] l1d_tag_out;
    logic        l1d_valid_in;
    logic        l1d_ready_out;
    logic [63:0] l1d_value_in;
    logic [TAG_BITS-1:0] l1d_tag_in;
    logic        l1d_write_complete_in;
    logic        resp_valid_out;
    logic        resp_ready_in;
    logic [63:0] resp_value_out;
    logic        resp_we_out;
    logic        tag_err_out;
`ifdef LSU_RQ_STATS_EN
    logic [31:0] stat_issued_out, stat_stall_out, stat_ooo_out;
`endif

    always #5 clk_in = ~clk_in;

    lsu_reorder_queue #(
        .DEPTH(DEPTH), .TAG_BITS(TAG_BITS), .ADDR_BITS(64), .DATA_BITS(64)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .core_valid_in(core_valid_in), .core_ready_out(core_ready_out),
        .core_addr_in(core_addr_in), .core_value_in(core_value_in), .core_we_in(core_we_in),
        .l1d_valid_out(l1d_valid_out), .l1d_ready_in(l1d_ready_in),
        .l1d_addr_out(l1d_addr_out), .l1d_value_out(l1d_value_out),
        .l1d_we_out(l1d_we_out), .l1d_tag_out(l1d_tag_out),
        .l1d_valid_in(l1d_valid_in), .l1d_ready_out(l1d_ready_out),
        .l1d_value_in(l1d_value_in), .l1d_tag_in(l1d_tag_in),
        .l1d_write_complete_in(l1d_write_complete_in),
        .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
        .resp_value_out(resp_value_out), .resp_we_out(resp_we_out),
`ifdef LSU_RQ_STATS_EN
        .stat_issued_out(stat_issued_out), .stat_stall_out(stat_stall_out),
        .stat_ooo_out(stat_ooo_out),
`endif
        .tag_err_out(tag_err_out)
    );

    // Model: outstanding requests in program order; st 0=waiting, 1=sent to L1D, 2=answered.
    typedef struct {
        logic [63:0] addr;
        logic [63:0] val;
        logic        we;
        int          st;
        logic [63:0] rdata;
        int          tag;
    } ment_t;

    ment_t       mq[$];
    int          alloc_seq;
    bit          m_err, m_rdy;
    int unsigned m_issued, m_stall, m_ooo;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int    iss_i, hit;
        bit    do_alloc, do_ret, can_take;
        ment_t e;
        forever begin
            @(posedge clk_in or posedge rst_in);
            if (rst_in) begin
                mq.delete();
                alloc_seq = 0; m_err = 0; m_rdy = 0;
                m_issued = 0; m_stall = 0; m_ooo = 0;
            end else begin
                iss_i = -1;
                foreach (mq[i]) if (mq[i].st == 0 && iss_i < 0) iss_i = i;
                can_take = m_rdy && mq.size() < DEPTH;
                do_alloc = core_valid_in && can_take;
                do_ret   = mq.size() > 0 && mq[0].st == 2 && resp_ready_in;
                if (core_valid_in && !can_take) m_stall++;
                if (l1d_valid_in) begin
                    hit = -1;
                    if (int'(l1d_tag_in) < DEPTH)
                        foreach (mq[i]) if (mq[i].tag == int'(l1d_tag_in) && mq[i].st == 1) hit = i;
                    if (hit >= 0) begin
                        mq[hit].st    = 2;
                        mq[hit].rdata = (mq[hit].we || l1d_write_complete_in) ? 64'd0 : l1d_value_in;
                        if (mq[hit].tag != mq[0].tag) m_ooo++;
                    end else begin
                        m_err = 1;
                    end
                end
                if (iss_i >= 0 && l1d_ready_in) begin
                    mq[iss_i].st = 1;
                    m_issued++;
                end
                if (do_ret) void'(mq.pop_front());
                if (do_alloc) begin
                    e.addr = core_addr_in; e.val = core_value_in; e.we = core_we_in;
                    e.st = 0; e.rdata = 64'd0; e.tag = alloc_seq % DEPTH;
                    mq.push_back(e);
                    alloc_seq++;
                end
                m_rdy = 1;
            end
        end
    end

    task automatic compare_all();
        int iss_i;
        if (rst_in) begin
            chk("rst core_ready", 64'(core_ready_out), 64'd0);
            chk("rst l1d_valid", 64'(l1d_valid_out), 64'd0);
            chk("rst l1d_ready", 64'(l1d_ready_out), 64'd0);
            chk("rst resp_valid", 64'(resp_valid_out), 64'd0);
            chk("rst tag_err", 64'(tag_err_out), 64'd0);
            return;
        end
        iss_i = -1;
        foreach (mq[i]) if (mq[i].st == 0 && iss_i < 0) iss_i = i;
        chk("core_ready", 64'(core_ready_out), 64'(m_rdy && mq.size() < DEPTH));
        chk("l1d_ready", 64'(l1d_ready_out), 64'd1);
        chk("tag_err", 64'(tag_err_out), 64'(m_err));
        chk("l1d_valid", 64'(l1d_valid_out), 64'(iss_i >= 0));
        if (iss_i >= 0 && l1d_valid_out) begin
            chk("l1d_addr", l1d_addr_out, mq[iss_i].addr);
            chk("l1d_value", l1d_value_out, mq[iss_i].val);
            chk("l1d_we", 64'(l1d_we_out), 64'(mq[iss_i].we));
            chk("l1d_tag", 64'(l1d_tag_out), 64'(mq[iss_i].tag));
        end
        chk("resp_valid", 64'(resp_valid_out), 64'(mq.size() > 0 && mq[0].st == 2));
        if (mq.size() > 0 && mq[0].st == 2 && resp_valid_out) begin
            chk("resp_value", resp_value_out, mq[0].rdata);
            chk("resp_we", 64'(resp_we_out), 64'(mq[0].we));
        end
`ifdef LSU_RQ_STATS_EN
        chk("stat_issued", 64'(stat_issued_out), 64'(m_issued));
        chk("stat_stall", 64'(stat_stall_out), 64'(m_stall));
        chk("stat_ooo", 64'(stat_ooo_out), 64'(m_ooo));
`endif
    endtask

    initial begin
        forever begin
            @(negedge clk_in);
            compare_all();
        end
    end

    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    task automatic clear_inputs();
        core_valid_in = 0; core_addr_in = '0; core_value_in = '0; core_we_in = 0;
        l1d_ready_in = 0; l1d_valid_in = 0; l1d_value_in = '0; l1d_tag_in = '0;
        l1d_write_complete_in = 0; resp_ready_in = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_in = 1;
        repeat (2) step();
        rst_in = 0;
        step();
    endtask

    task automatic send_rsp(input int tag, input logic [63:0] val, input logic wc);
        l1d_valid_in = 1; l1d_tag_in = TAG_BITS'(tag); l1d_value_in = val;
        l1d_write_complete_in = wc;
        step();
        l1d_valid_in = 0; l1d_write_complete_in = 0;
    endtask

    initial begin
        logic [63:0] addrs[4];
        int          order[4];
        int          cand[$];
        bit          cand_we[$];
        int          k;
        rst_in = 1;
        do_reset();

        // Single load round trip.
        l1d_ready_in = 1; resp_ready_in = 1;
        core_valid_in = 1; core_addr_in = 64'h2000; core_we_in = 0;
        step();
        core_valid_in = 0;
        chk("t1 issue valid", 64'(l1d_valid_out), 64'd1);
        chk("t1 issue addr", l1d_addr_out, 64'h2000);
        chk("t1 issue tag", 64'(l1d_tag_out), 64'd0);
        step();
        chk("t1 issued once", 64'(l1d_valid_out), 64'd0);
        send_rsp(0, 64'h12345678, 0);
        chk("t1 resp valid", 64'(resp_valid_out), 64'd1);
        chk("t1 resp value", resp_value_out, 64'h12345678);
        step();
        chk("t1 retired", 64'(resp_valid_out), 64'd0);

        // Out-of-order completion, in-order retirement.
        do_reset();
        addrs[0] = 64'h5000; addrs[1] = 64'h7004; addrs[2] = 64'h9004; addrs[3] = 64'hF004;
        order[0] = 2; order[1] = 0; order[2] = 3; order[3] = 1;
        l1d_ready_in = 1;
        for (int i = 0; i < 4; i++) begin
            core_valid_in = 1; core_addr_in = addrs[i];
            step();
        end
        core_valid_in = 0;
        step();
        l1d_ready_in = 0;
        for (int i = 0; i < 4; i++) send_rsp(order[i], addrs[order[i]], 0);
`ifdef LSU_RQ_STATS_EN
        chk("t2 stat_ooo", 64'(stat_ooo_out), 64'd3);
`endif
        resp_ready_in = 1;
        for (int i = 0; i < 4; i++) begin
            chk("t2 in-order value", resp_value_out, addrs[i]);
            step();
        end
        resp_ready_in = 0;

        // Full queue backpressure.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            core_valid_in = 1; core_addr_in = 64'h100 + 64'(i);
            step();
        end
        core_addr_in = 64'hA000;
        chk("t3 full not ready", 64'(core_ready_out), 64'd0);
        step();
        chk("t3 still full", 64'(core_ready_out), 64'd0);
        l1d_ready_in = 1;
        repeat (4) step();
        l1d_ready_in = 0;
        send_rsp(0, 64'h55, 0);
        resp_ready_in = 1;
        step();
        resp_ready_in = 0;
        chk("t3 ready after retire", 64'(core_ready_out), 64'd1);
        step();
        core_valid_in = 0;
        chk("t3 full again", 64'(core_ready_out), 64'd0);
        chk("t3 new tag", 64'(l1d_tag_out), 64'd0);
        chk("t3 new addr", l1d_addr_out, 64'hA000);

        // Store held by L1D backpressure, then bad-tag response.
        do_reset();
        core_valid_in = 1; core_addr_in = 64'h4050; core_value_in = 64'hC0C0C0C0; core_we_in = 1;
        step();
        core_valid_in = 0; core_we_in = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t4 hold valid", 64'(l1d_valid_out), 64'd1);
            chk("t4 hold addr", l1d_addr_out, 64'h4050);
            chk("t4 hold data", l1d_value_out, 64'hC0C0C0C0);
            chk("t4 hold we", 64'(l1d_we_out), 64'd1);
            step();
        end
        l1d_ready_in = 1;
        step();
        l1d_ready_in = 0;
        send_rsp(0, 64'hDEAD, 1);
        chk("t4 resp we", 64'(resp_we_out), 64'd1);
        chk("t4 resp value", resp_value_out, 64'd0);
        resp_ready_in = 1;
        step();
        resp_ready_in = 0;
        send_rsp(2, 64'h1, 0);
        chk("t5 tag_err", 64'(tag_err_out), 64'd1);
        chk("t5 no resp", 64'(resp_valid_out), 64'd0);

        // Reset with requests in flight.
        do_reset();
        l1d_ready_in = 1;
        for (int i = 0; i < 3; i++) begin
            core_valid_in = 1; core_addr_in = 64'h800 + 64'(i * 8);
            step();
        end
        core_valid_in = 0;
        step();
        l1d_ready_in = 0;
        rst_in = 1;
        #1;
        chk("t6 rst l1d_valid", 64'(l1d_valid_out), 64'd0);
        chk("t6 rst core_ready", 64'(core_ready_out), 64'd0);
        chk("t6 rst tag_err", 64'(tag_err_out), 64'd0);
        step();
        rst_in = 0;
        send_rsp(1, 64'h77, 0);
        chk("t6 late tag_err", 64'(tag_err_out), 64'd1);

        // Random traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            core_valid_in = ($urandom % 2) == 0;
            core_addr_in  = {$urandom, $urandom};
            core_value_in = {$urandom, $urandom};
            core_we_in    = ($urandom % 2) == 0;
            l1d_ready_in  = ($urandom % 4) != 0;
            resp_ready_in = ($urandom % 3) != 0;
            l1d_valid_in  = 0; l1d_write_complete_in = 0;
            cand.delete(); cand_we.delete();
            foreach (mq[i]) if (mq[i].st == 1) begin
                cand.push_back(mq[i].tag); cand_we.push_back(mq[i].we);
            end
            if (($urandom % 200) == 0) begin
                l1d_valid_in = 1; l1d_tag_in = TAG_BITS'($urandom);
                l1d_value_in = {$urandom, $urandom};
            end else if (cand.size() > 0 && ($urandom % 2) == 0) begin
                k = int'($urandom_range(0, cand.size() - 1));
                l1d_valid_in = 1; l1d_tag_in = TAG_BITS'(cand[k]);
                l1d_value_in = {$urandom, $urandom};
                l1d_write_complete_in = cand_we[k];
            end
            step();
        end
        clear_inputs();
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
